// File: rtl/cmdline_ctrl.sv
// Command-line buffer controller: stores keystrokes, handles backspace/echo,
// terminates on Enter, lends the buffer to the matcher, then NUL-fills it.
module cmdline_ctrl #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int SCAN_TO = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [DW-1:0] echo_data,
    output logic          echo_valid,
    input  logic          echo_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          scan_start,
    input  logic [AW-1:0] scan_addr,
    output logic [DW-1:0] scan_rdata,
    input  logic          scan_done,
    output logic          scan_timeout,
    output logic [AW-1:0] len,
    output logic          overflow
);
    localparam int CW = $clog2(SCAN_TO);
    localparam logic [AW-1:0] LEN_MAX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(SCAN_TO - 1);

    typedef enum logic [2:0] {IDLE, ECHO, TERM, SCAN, CLEAR} state_t;

    state_t        state;
    logic [AW-1:0] clr_idx;
    logic [CW-1:0] cnt;
    logic          scan_first;
    logic [DW-1:0] echo_q;
    logic          ovf_q;
    logic          xfer, is_print, is_bs, is_cr;

    assign is_print = (rx_data >= DW'(8'h20) && rx_data <= DW'(8'h7E)) || rx_data == DW'(8'h1B);
    assign is_bs    = rx_data == DW'(8'h08) || rx_data == DW'(8'h7F);
    assign is_cr    = rx_data == DW'(8'h0D);

    always_comb begin
        rx_ready     = state == IDLE;
        xfer         = rx_valid && rx_ready;
        echo_valid   = state == ECHO;
        echo_data    = echo_q;
        overflow     = ovf_q;
        scan_start   = state == SCAN && scan_first;
        scan_timeout = state == SCAN && !scan_done && cnt == TO_LAST;
        scan_rdata   = (state == SCAN) ? mem_rdata : '0;
        mem_we       = 1'b0;
        mem_addr     = len;
        mem_wdata    = '0;
        case (state)
            IDLE: begin
                // Store in the same cycle as the handshake, at the current tail.
                if (xfer && is_print && len != LEN_MAX) begin
                    mem_we    = 1'b1;
                    mem_wdata = rx_data;
                end
            end
            TERM:  mem_we = 1'b1;
            SCAN:  mem_addr = scan_addr;
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            len        <= '0;
            ovf_q      <= 1'b0;
            echo_q     <= '0;
            cnt        <= '0;
            clr_idx    <= '0;
            scan_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (is_print) begin
                            if (len != LEN_MAX) begin
                                len    <= len + AW'(1);
                                echo_q <= rx_data;
                            end else begin
                                ovf_q  <= 1'b1;
                                echo_q <= DW'(8'h07);
                            end
                            state <= ECHO;
                        end else if (is_bs && len != '0) begin
                            len    <= len - AW'(1);
                            echo_q <= DW'(8'h08);
                            state  <= ECHO;
                        end else if (is_cr) begin
                            state <= TERM;
                        end
                    end
                end
                ECHO: if (echo_ready) state <= IDLE;
                TERM: begin
                    state      <= SCAN;
                    cnt        <= '0;
                    scan_first <= 1'b1;
                end
                SCAN: begin
                    scan_first <= 1'b0;
                    cnt        <= cnt + CW'(1);
                    // scan_done wins over a coincident timeout; both leave via CLEAR.
                    if (scan_done || cnt == TO_LAST) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_idx == len) begin
                        len   <= '0;
                        ovf_q <= 1'b0;
                        state <= IDLE;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmdline_ctrl.sv
// Directed bench for cmdline_ctrl: line entry, editing, overflow, scan
// handoff, timeout, echo back-pressure and mid-scan reset.
module tb_cmdline_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] echo_data;
    logic       echo_valid;
    logic       echo_ready = 1'b1;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       scan_start;
    logic [4:0] scan_addr = '0;
    logic [7:0] scan_rdata;
    logic       scan_done = 1'b0;
    logic       scan_timeout;
    logic [4:0] len;
    logic       overflow;

    logic [7:0] mem [32];
    int wlog[$];
    int elog[$];
    int ev_cnt, ss_cnt, to_cnt;
    int n_vec = 0, n_err = 0;

    cmdline_ctrl dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .echo_data(echo_data), .echo_valid(echo_valid), .echo_ready(echo_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .scan_start(scan_start), .scan_addr(scan_addr), .scan_rdata(scan_rdata),
        .scan_done(scan_done), .scan_timeout(scan_timeout), .len(len), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wlog.push_back(int'(mem_addr) * 256 + int'(mem_wdata));
        end
        if (echo_valid) ev_cnt++;
        if (echo_valid && echo_ready) elog.push_back(int'(echo_data));
        if (scan_start) ss_cnt++;
        if (scan_timeout) to_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clr_logs();
        wlog.delete();
        elog.delete();
        ev_cnt = 0;
        ss_cnt = 0;
        to_cnt = 0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("rdy_wait", 0, 1);
    endtask

    task automatic key(input logic [7:0] b);
        @(negedge clk);
        wait_ready();
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_start();
        int t = 0;
        while (!scan_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("start_wait", 0, 1);
    endtask

    // Enter, then raise scan_done dly cycles after the scan_start cycle.
    task automatic enter(input int dly);
        key(8'h0D);
        wait_start();
        repeat (dly) @(negedge clk);
        scan_done = 1'b1;
        @(negedge clk);
        scan_done = 1'b0;
        wait_ready();
    endtask

    initial begin
        int n;
        int exp_w[6];
        clr_logs();
        // reset state
        #12;
        chk("rst_len", len, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_rdy", rx_ready, 1);
        chk("rst_pulses", {echo_valid, mem_we, scan_start, scan_timeout}, 0);
        chk("rst_srd", scan_rdata, 0);
        @(negedge clk);
        rst = 1'b1;

        // "ls" + Enter, scan_done 5 cycles after scan_start
        key(8'h6C);
        key(8'h73);
        key(8'h0D);
        wait_start();
        scan_addr = 5'd1;
        #1;
        chk("scan_rdata", scan_rdata, 8'h73);
        chk("scan_maddr", mem_addr, 1);
        chk("scan_we", mem_we, 0);
        repeat (5) @(negedge clk);
        scan_done = 1'b1;
        @(negedge clk);
        scan_done = 1'b0;
        wait_ready();
        exp_w = '{16'h006C, 16'h0173, 16'h0200, 16'h0000, 16'h0100, 16'h0200};
        chk("ls_wcnt", wlog.size(), 6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) chk($sformatf("ls_w%0d", i), wlog[i], exp_w[i]);
        chk("ls_ecnt", elog.size(), 2);
        if (elog.size() == 2) begin
            chk("ls_e0", elog[0], 8'h6C);
            chk("ls_e1", elog[1], 8'h73);
        end
        chk("ls_start", ss_cnt, 1);
        chk("ls_len", len, 0);

        // "ab", BS, "c"
        clr_logs();
        key(8'h61);
        key(8'h62);
        key(8'h08);
        key(8'h63);
        @(negedge clk);
        chk("bs_len", len, 2);
        chk("bs_m0", mem[0], 8'h61);
        chk("bs_m1", mem[1], 8'h63);
        chk("bs_ecnt", elog.size(), 4);
        if (elog.size() == 4) begin
            chk("bs_e0", elog[0], 8'h61);
            chk("bs_e1", elog[1], 8'h62);
            chk("bs_e2", elog[2], 8'h08);
            chk("bs_e3", elog[3], 8'h63);
        end
        enter(2);
        chk("bs_len0", len, 0);

        // backspace on empty line
        clr_logs();
        key(8'h7F);
        @(negedge clk);
        chk("bs0_w", wlog.size(), 0);
        chk("bs0_ev", ev_cnt, 0);
        chk("bs0_len", len, 0);

        // 33 printable keys: 31 stored, last two bell
        clr_logs();
        for (int i = 0; i < 33; i++) key(8'h41 + 8'(i % 26));
        @(negedge clk);
        chk("ov_len", len, 31);
        chk("ov_flag", overflow, 1);
        chk("ov_wcnt", wlog.size(), 31);
        chk("ov_ecnt", elog.size(), 33);
        if (elog.size() == 33) begin
            chk("ov_e30", elog[30], 8'h45);
            chk("ov_e31", elog[31], 8'h07);
            chk("ov_e32", elog[32], 8'h07);
        end
        clr_logs();
        enter(3);
        chk("ov_flag0", overflow, 0);
        chk("ov_len0", len, 0);
        chk("ov_cwcnt", wlog.size(), 33);
        if (wlog.size() == 33) begin
            chk("ov_term", wlog[0], 16'h1F00);
            chk("ov_c0", wlog[1], 16'h0000);
            chk("ov_c31", wlog[32], 16'h1F00);
        end

        // scan timeout
        clr_logs();
        key(8'h0D);
        wait_start();
        n = 1;
        while (!scan_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 64);
        wait_ready();
        @(negedge clk);
        chk("to_cnt", to_cnt, 1);
        chk("to_rdy", rx_ready, 1);

        // echo back-pressure
        clr_logs();
        echo_ready = 1'b0;
        key(8'h41);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", echo_valid, 1);
            chk("bp_data", echo_data, 8'h41);
            chk("bp_rdy", rx_ready, 0);
            @(negedge clk);
        end
        echo_ready = 1'b1;
        @(negedge clk);
        chk("bp_done", elog.size(), 1);

        // reset mid-SCAN
        key(8'h0D);
        wait_start();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_len", len, 0);
        chk("mr_pulses", {echo_valid, mem_we, scan_start, scan_timeout}, 0);
        chk("mr_rdy", rx_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_idle", rx_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
